aes_job_scheduler: RTL and testbench

Two-requester front-end scheduler for the 8-bit AES round datapath. Accepts encryption jobs (data byte + key byte) from two requesters over valid/ready handshakes and arbitrates between them round-robin. Sequences the single-round engine through load, NUM_ROUNDS round steps and result capture, then returns the result to the granted requester. Sits between the tile I/O glue and the round engine; the scheduler owns the round counter.

---
 rtl/aes_ctrl_pkg.sv | 23 ++
 rtl/rr_arbiter2.sv | 41 ++++
 rtl/aes_job_scheduler.sv | 135 +++++++++++++
 tb/tb_aes_job_scheduler.sv | 331 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_ctrl_pkg.sv
// +--------------------------------------------------------------------+
// | aes_ctrl_pkg: shared types and defaults for the AES job scheduler  |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

package aes_ctrl_pkg;

    localparam int DEFAULT_NUM_ROUNDS = 10;

    typedef logic rid_t;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LOAD    = 3'd1,
        ROUND   = 3'd2,
        CAPTURE = 3'd3,
        RESP    = 3'd4
    } state_e;

endpackage

`default_nettype wire

// File: rtl/rr_arbiter2.sv
// +--------------------------------------------------------------------+
// | rr_arbiter2: two-way round-robin arbiter with last-grant history   |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

module rr_arbiter2
    import aes_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       update,
    output rid_t       grant,
    output logic       grant_valid
);

    rid_t r_last_grant;

    always_comb begin
        grant       = ~r_last_grant;
        grant_valid = |req;
        case (req)
            2'b01:   grant = 1'b0;
            2'b10:   grant = 1'b1;
            default: grant = ~r_last_grant;
        endcase
    end

    // Reset to 1 so that requester 0 wins the very first tie.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_last_grant <= 1'b1;
        end else if (update) begin
            r_last_grant <= grant;
        end
    end

endmodule

`default_nettype wire

// File: rtl/aes_job_scheduler.sv
// +--------------------------------------------------------------------+
// | aes_job_scheduler: two-requester front end for the AES round engine|
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

module aes_job_scheduler
    import aes_ctrl_pkg::*;
#(
    parameter int NUM_ROUNDS = DEFAULT_NUM_ROUNDS,
    parameter int RIDX_W     = $clog2(NUM_ROUNDS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic [1:0]        req_valid,
    output logic [1:0]        req_ready,
    input  logic [1:0][7:0]   req_data,
    input  logic [1:0][7:0]   req_key,
    output logic [1:0]        resp_valid,
    input  logic [1:0]        resp_ready,
    output logic [7:0]        resp_data,
    output logic              eng_load,
    output logic [7:0]        eng_data,
    output logic [7:0]        eng_key,
    output logic              eng_step,
    output logic [RIDX_W-1:0] eng_round_idx,
    input  logic [7:0]        eng_result,
    output logic              busy
);

    localparam logic [RIDX_W-1:0] C_LAST_IDX = RIDX_W'(NUM_ROUNDS - 1);

    state_e            r_state;
    state_e            w_next;
    logic [RIDX_W-1:0] r_idx;
    logic [7:0]        r_data;
    logic [7:0]        r_key;
    logic [7:0]        r_resp;
    rid_t              r_gid;
    rid_t              w_grant;
    logic              w_grant_valid;
    logic              w_accept;

    rr_arbiter2 u_arb (
        .clk         (clk),
        .rst         (rst),
        .req         (req_valid),
        .update      (w_accept),
        .grant       (w_grant),
        .grant_valid (w_grant_valid)
    );

    assign w_accept = |(req_valid & req_ready);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next     = r_state;
        req_ready  = '0;
        resp_valid = '0;
        eng_load   = 1'b0;
        eng_step   = 1'b0;
        busy       = (r_state != IDLE);
        case (r_state)
            IDLE: begin
                // rst gating keeps ready low for the whole reset window.
                if (w_grant_valid && !flush && !rst) begin
                    req_ready[w_grant] = 1'b1;
                    w_next             = LOAD;
                end
            end
            LOAD: begin
                eng_load = 1'b1;
                w_next   = ROUND;
            end
            ROUND: begin
                eng_step = 1'b1;
                if (r_idx == C_LAST_IDX) begin
                    w_next = CAPTURE;
                end
            end
            CAPTURE: begin
                w_next = RESP;
            end
            RESP: begin
                resp_valid[r_gid] = 1'b1;
                if (resp_ready[r_gid]) begin
                    w_next = IDLE;
                end
            end
            default: begin
                w_next = IDLE;
            end
        endcase
        if (flush && (r_state != IDLE)) begin
            w_next = IDLE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_idx  <= '0;
            r_data <= '0;
            r_key  <= '0;
            r_resp <= '0;
            r_gid  <= 1'b0;
        end else begin
            if (w_accept) begin
                r_data <= req_data[w_grant];
                r_key  <= req_key[w_grant];
                r_gid  <= w_grant;
            end
            // Index only survives while staying in ROUND; any exit clears it.
            r_idx <= ((r_state == ROUND) && (w_next == ROUND)) ? r_idx + 1'b1 : '0;
            if ((r_state == CAPTURE) && !flush) begin
                r_resp <= eng_result;
            end
        end
    end

    assign eng_data      = r_data;
    assign eng_key       = r_key;
    assign eng_round_idx = r_idx;
    assign resp_data     = r_resp;

endmodule

`default_nettype wire

// File: tb/tb_aes_job_scheduler.sv
// +--------------------------------------------------------------------+
// | tb_aes_job_scheduler: scoreboard bench with a stub XOR round engine|
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

module tb_aes_job_scheduler;

    localparam int NR = 10;
    localparam int RW = $clog2(NR);

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            flush = 1'b0;
    logic [1:0]      req_valid = '0;
    logic [1:0]      req_ready;
    logic [1:0][7:0] req_data = '0;
    logic [1:0][7:0] req_key = '0;
    logic [1:0]      resp_valid;
    logic [1:0]      resp_ready = '0;
    logic [7:0]      resp_data;
    logic            eng_load;
    logic [7:0]      eng_data;
    logic [7:0]      eng_key;
    logic            eng_step;
    logic [RW-1:0]   eng_round_idx;
    logic [7:0]      eng_result;
    logic            busy;

    aes_job_scheduler #(.NUM_ROUNDS(NR)) dut (
        .clk           (clk),
        .rst           (rst),
        .flush         (flush),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_data      (req_data),
        .req_key       (req_key),
        .resp_valid    (resp_valid),
        .resp_ready    (resp_ready),
        .resp_data     (resp_data),
        .eng_load      (eng_load),
        .eng_data      (eng_data),
        .eng_key       (eng_key),
        .eng_step      (eng_step),
        .eng_round_idx (eng_round_idx),
        .eng_result    (eng_result),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    // Stub engine: load acc = data ^ key, each step XORs in the round index.
    logic [7:0] acc = '0;
    always @(posedge clk) begin
        if (eng_load)      acc <= eng_data ^ eng_key;
        else if (eng_step) acc <= acc ^ 8'(eng_round_idx);
    end
    assign eng_result = acc;

    typedef struct {
        int         rid;
        logic [7:0] data;
    } exp_t;

    exp_t       sb[$];
    int         acc_cyc[$];
    int         resp_cyc[$];
    int         n_cmp = 0;
    int         n_err = 0;
    int         cyc = 0;
    logic [7:0] last_resp = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    function automatic logic [7:0] model(input logic [7:0] d, input logic [7:0] k);
        logic [7:0] r;
        r = d ^ k;
        for (int i = 0; i < NR; i++) r = r ^ 8'(i);
        return r;
    endfunction

    // Scoreboard: push at accept, drop on flush/reset, pop at response handshake.
    always @(negedge clk) begin
        if (rst) begin
            sb.delete();
        end else begin
            if (flush && busy && sb.size() > 0) void'(sb.pop_back());
            for (int i = 0; i < 2; i++) begin
                if (req_valid[i] && req_ready[i]) begin
                    sb.push_back('{rid: i, data: model(req_data[i], req_key[i])});
                    acc_cyc.push_back(cyc);
                end
            end
            if (resp_valid != 2'b00) begin
                check("resp_onehot", {31'd0, resp_valid == 2'b11}, 32'd0);
            end
            for (int i = 0; i < 2; i++) begin
                if (resp_valid[i] && resp_ready[i]) begin
                    if (sb.size() == 0) begin
                        check("sb_underflow", 32'd1, 32'd0);
                    end else begin
                        exp_t e;
                        e = sb.pop_front();
                        check("resp_rid", i, e.rid);
                        check("resp_data", {24'd0, resp_data}, {24'd0, e.data});
                        last_resp = resp_data;
                        resp_cyc.push_back(cyc);
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_any_accept(input bit drop, output int who);
        bit found;
        found = 1'b0;
        who   = -1;
        for (int n = 0; n < 300 && !found; n++) begin
            @(negedge clk);
            if ((req_valid & req_ready) != 2'b00) begin
                found = 1'b1;
                who   = req_ready[1] ? 1 : 0;
            end
        end
        if (!found) begin
            check("accept_timeout", 32'd0, 32'd1);
        end else begin
            @(posedge clk);
            #1;
            if (drop) req_valid[who] = 1'b0;
        end
    endtask

    task automatic wait_drain();
        bit done;
        done = 1'b0;
        for (int n = 0; n < 400 && !done; n++) begin
            tick();
            if (sb.size() == 0 && !busy) done = 1'b1;
        end
        if (!done) check("drain_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        int w;
        bit hit;

        // Reset values while reset is held
        #2;
        check("rst_req_ready", {30'd0, req_ready}, 32'd0);
        check("rst_resp_valid", {30'd0, resp_valid}, 32'd0);
        check("rst_ctrl", {29'd0, eng_load, eng_step, busy}, 32'd0);
        check("rst_vals", {eng_data, eng_key, resp_data, 8'(eng_round_idx)}, 32'd0);
        tick();
        rst = 1'b0;

        // Test 1: single job, full timing walk
        resp_ready  = 2'b11;
        req_data[0] = 8'hAA;
        req_key[0]  = 8'h55;
        req_valid   = 2'b01;
        wait_any_accept(1'b1, w);
        check("t1_who", w, 0);
        check("t1_load", {31'd0, eng_load}, 32'd1);
        check("t1_latch", {16'd0, eng_data, eng_key}, 32'h0000AA55);
        for (int k = 0; k < NR; k++) begin
            tick();
            check("t1_step", {31'd0, eng_step}, 32'd1);
            check("t1_idx", 32'(eng_round_idx), k);
        end
        tick();
        check("t1_capture", {29'd0, eng_step, resp_valid}, 32'd0);
        tick();
        check("t1_resp_valid", {30'd0, resp_valid}, 32'd1);
        check("t1_resp_data", {24'd0, resp_data}, 32'hFE);
        tick();
        check("t1_idle", {31'd0, busy}, 32'd0);
        check("t1_idx_idle", 32'(eng_round_idx), 32'd0);

        // Test 2: simultaneous requests from reset
        rst = 1'b1;
        #2;
        rst = 1'b0;
        acc_cyc.delete();
        resp_cyc.delete();
        req_data  = {8'hFF, 8'h12};
        req_key   = {8'hFF, 8'h34};
        req_valid = 2'b11;
        wait_any_accept(1'b1, w);
        check("t2_first", w, 0);
        wait_any_accept(1'b1, w);
        check("t2_second", w, 1);
        wait_drain();
        check("t2_last_resp", {24'd0, last_resp}, 32'h01);
        if (acc_cyc.size() == 2 && resp_cyc.size() == 2) begin
            check("t2_acc_gap", acc_cyc[1] - acc_cyc[0], 14);
            check("t2_resp_gap", resp_cyc[1] - resp_cyc[0], 14);
            check("t2_latency", resp_cyc[0] - acc_cyc[0], 13);
        end else begin
            check("t2_event_count", acc_cyc.size() + resp_cyc.size(), 4);
        end

        // Test 3: both continuously valid, grants alternate
        req_data  = {8'($urandom), 8'($urandom)};
        req_key   = {8'($urandom), 8'($urandom)};
        req_valid = 2'b11;
        for (int j = 0; j < 4; j++) begin
            wait_any_accept(1'b0, w);
            check("t3_grant", w, j % 2);
            if (w >= 0) begin
                req_data[w] = 8'($urandom);
                req_key[w]  = 8'($urandom);
            end
        end
        req_valid = 2'b00;
        wait_drain();

        // Test 4: response stall with a competing request pending
        resp_ready  = 2'b00;
        req_data[0] = 8'hAA;
        req_key[0]  = 8'h55;
        req_valid   = 2'b01;
        wait_any_accept(1'b1, w);
        req_data[1] = 8'h11;
        req_key[1]  = 8'h22;
        req_valid   = 2'b10;
        hit = 1'b0;
        for (int n = 0; n < 40 && !hit; n++) begin
            tick();
            if (resp_valid != 2'b00) hit = 1'b1;
        end
        check("t4_resp_seen", {31'd0, hit}, 32'd1);
        for (int n = 0; n < 5; n++) begin
            check("t4_hold_valid", {30'd0, resp_valid}, 32'd1);
            check("t4_hold_data", {24'd0, resp_data}, 32'hFE);
            check("t4_no_ready", {30'd0, req_ready}, 32'd0);
            tick();
        end
        resp_ready = 2'b11;
        tick();
        check("t4_idle", {31'd0, busy}, 32'd0);
        check("t4_ready1", {30'd0, req_ready}, 32'd2);
        wait_any_accept(1'b1, w);
        check("t4_who", w, 1);
        wait_drain();
        check("t4_last_resp", {24'd0, last_resp}, 32'h32);

        // Test 5: flush at round index 4 of a req1 job
        req_data[1] = 8'h5A;
        req_key[1]  = 8'hA5;
        req_valid   = 2'b10;
        wait_any_accept(1'b1, w);
        check("t5_who", w, 1);
        hit = 1'b0;
        for (int n = 0; n < 20 && !hit; n++) begin
            tick();
            if (eng_step && eng_round_idx == RW'(4)) hit = 1'b1;
        end
        check("t5_idx4_seen", {31'd0, hit}, 32'd1);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("t5_idle", {31'd0, busy}, 32'd0);
        check("t5_idx_clr", 32'(eng_round_idx), 32'd0);
        for (int n = 0; n < 3; n++) begin
            check("t5_no_resp", {30'd0, resp_valid}, 32'd0);
            tick();
        end
        req_data  = {8'h01, 8'h02};
        req_key   = {8'h03, 8'h04};
        req_valid = 2'b11;
        wait_any_accept(1'b1, w);
        check("t5_tie_grant", w, 0);
        wait_any_accept(1'b1, w);
        check("t5_then_req1", w, 1);
        wait_drain();

        // Test 6: asynchronous reset during ROUND
        req_data[0] = 8'h77;
        req_key[0]  = 8'h88;
        req_valid   = 2'b01;
        wait_any_accept(1'b1, w);
        hit = 1'b0;
        for (int n = 0; n < 10 && !hit; n++) begin
            tick();
            if (eng_step) hit = 1'b1;
        end
        check("t6_in_round", {31'd0, hit}, 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check("t6_rst_ctrl", {29'd0, eng_load, eng_step, busy}, 32'd0);
        check("t6_rst_hs", {28'd0, req_ready, resp_valid}, 32'd0);
        check("t6_rst_vals", {eng_data, eng_key, resp_data, 8'(eng_round_idx)}, 32'd0);
        tick();
        rst = 1'b0;
        req_data[0] = 8'h00;
        req_key[0]  = 8'h00;
        req_valid   = 2'b01;
        wait_any_accept(1'b1, w);
        check("t6_who", w, 0);
        wait_drain();
        check("t6_last_resp", {24'd0, last_resp}, 32'h01);
        check("sb_empty", sb.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: got running, expected finished");
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire
